// File: rtl/fu_dispatch_pkg.sv
// ---------------------------------------------------------------------------
// fu_dispatch_pkg
// Shared decode/dispatch definitions: functional-unit select encoding and
// width, plus a legality helper for the one-hot select.
// ---------------------------------------------------------------------------
package fu_dispatch_pkg;

    localparam int FU_W = 3;

    typedef logic [FU_W-1:0] fu_type_t;

    localparam fu_type_t FU_ALU = 3'b001;
    localparam fu_type_t FU_LSQ = 3'b010;
    localparam fu_type_t FU_BRA = 3'b100;

    // Anything other than exactly one of the three unit selects is discarded.
    function automatic logic fu_type_legal(input fu_type_t t);
        return (t == FU_ALU) || (t == FU_LSQ) || (t == FU_BRA);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// ---------------------------------------------------------------------------
// credit_counter
// Tracks free slots in one downstream unit. Starts full (DEPTH credits).
//   clk, rst : clock, asynchronous active-high reset
//   take     : a dispatch consumed one slot this cycle
//   give     : the unit returned one slot this cycle
//   credit   : current number of free slots, 0..DEPTH
// ---------------------------------------------------------------------------
module credit_counter #(
    parameter int DEPTH = 4,
    localparam int W    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         take,
    input  logic         give,
    output logic [W-1:0] credit
);

    localparam logic [W-1:0] CREDIT_MAX = W'(DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credit <= CREDIT_MAX;
        end else if (take && !give) begin
            credit <= credit - 1'b1;
        end else if (give && !take && (credit != CREDIT_MAX)) begin
            // Extra returns at full occupancy are dropped rather than wrapping.
            credit <= credit + 1'b1;
        end
    end

endmodule

// File: rtl/fu_dispatch.sv
// ---------------------------------------------------------------------------
// fu_dispatch
// One-entry dispatch stage between the decoder and three functional units
// (ALU, LSQ, branch). The held instruction is strobed to its unit when that
// unit has a free slot; a malformed unit select is dropped with an illegal
// pulse. Tags count dispatches and restart from 0 on flush.
//
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : pipeline flush, drops the held entry, clears tag
//   in_valid / in_ready : decoder handshake
//   in_fu_type          : one-hot unit select (FU_ALU/FU_LSQ/FU_BRA)
//   in_payload          : decoded instruction fields
//   alu/lsq/bra_valid   : dispatch strobes
//   out_payload, out_tag: held payload and its dispatch tag
//   alu/lsq/bra_free    : slot-return pulses from the units
//   illegal             : pulse when a bad unit select is discarded
//
// Optional build macro DISPATCH_STATS_EN adds saturating 32-bit outputs
//   stall_cycles   : cycles holding an entry that could not leave
//   dispatch_count : number of dispatch strobes
// ---------------------------------------------------------------------------
module fu_dispatch
    import fu_dispatch_pkg::*;
#(
    parameter int PAYLOAD_W = 64,
    parameter int TAG_W     = 4,
    parameter int ALU_DEPTH = 4,
    parameter int LSQ_DEPTH = 4,
    parameter int BRA_DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [FU_W-1:0]      in_fu_type,
    input  logic [PAYLOAD_W-1:0] in_payload,
    output logic                 alu_valid,
    output logic                 lsq_valid,
    output logic                 bra_valid,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic [TAG_W-1:0]     out_tag,
    input  logic                 alu_free,
    input  logic                 lsq_free,
    input  logic                 bra_free,
    output logic                 illegal
`ifdef DISPATCH_STATS_EN
    ,
    output logic [31:0]          stall_cycles,
    output logic [31:0]          dispatch_count
`endif
);

    localparam int ALU_CW = $clog2(ALU_DEPTH + 1);
    localparam int LSQ_CW = $clog2(LSQ_DEPTH + 1);
    localparam int BRA_CW = $clog2(BRA_DEPTH + 1);

    logic                 full_reg;
    fu_type_t             fu_type_reg;
    logic [PAYLOAD_W-1:0] payload_reg;
    logic [TAG_W-1:0]     tag_reg;

    logic [ALU_CW-1:0] alu_credit;
    logic [LSQ_CW-1:0] lsq_credit;
    logic [BRA_CW-1:0] bra_credit;

    logic live;
    logic fire;
    logic strobe;
    logic accept;

    // A flush cycle behaves as if nothing is held: no strobes, no discard.
    assign live      = full_reg && !flush;
    assign alu_valid = live && (fu_type_reg == FU_ALU) && (alu_credit != '0);
    assign lsq_valid = live && (fu_type_reg == FU_LSQ) && (lsq_credit != '0);
    assign bra_valid = live && (fu_type_reg == FU_BRA) && (bra_credit != '0);
    assign illegal   = live && !fu_type_legal(fu_type_reg);

    assign strobe = alu_valid || lsq_valid || bra_valid;
    assign fire   = strobe || illegal;

    // Ready is withheld during flush so the decoder never sees a handshake
    // that the holding register then ignores.
    assign in_ready = (!full_reg || fire) && !flush;
    assign accept   = in_valid && in_ready;

    assign out_payload = payload_reg;
    assign out_tag     = tag_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_reg    <= 1'b0;
            fu_type_reg <= '0;
            payload_reg <= '0;
            tag_reg     <= '0;
        end else if (flush) begin
            full_reg <= 1'b0;
            tag_reg  <= '0;
        end else begin
            if (accept) begin
                full_reg    <= 1'b1;
                fu_type_reg <= in_fu_type;
                payload_reg <= in_payload;
            end else if (fire) begin
                full_reg <= 1'b0;
            end
            if (strobe) begin
                tag_reg <= tag_reg + 1'b1;
            end
        end
    end

    credit_counter #(.DEPTH(ALU_DEPTH)) u_alu_credit (
        .clk(clk), .rst(rst), .take(alu_valid), .give(alu_free), .credit(alu_credit)
    );
    credit_counter #(.DEPTH(LSQ_DEPTH)) u_lsq_credit (
        .clk(clk), .rst(rst), .take(lsq_valid), .give(lsq_free), .credit(lsq_credit)
    );
    credit_counter #(.DEPTH(BRA_DEPTH)) u_bra_credit (
        .clk(clk), .rst(rst), .take(bra_valid), .give(bra_free), .credit(bra_credit)
    );

`ifdef DISPATCH_STATS_EN
    logic [31:0] stall_cycles_reg;
    logic [31:0] dispatch_count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles_reg   <= '0;
            dispatch_count_reg <= '0;
        end else begin
            if (full_reg && !fire && (stall_cycles_reg != 32'hFFFF_FFFF)) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
            if (strobe && (dispatch_count_reg != 32'hFFFF_FFFF)) begin
                dispatch_count_reg <= dispatch_count_reg + 1'b1;
            end
        end
    end

    assign stall_cycles   = stall_cycles_reg;
    assign dispatch_count = dispatch_count_reg;
`endif

endmodule

// File: tb/tb_fu_dispatch.sv
// ---------------------------------------------------------------------------
// tb_fu_dispatch
// Self-checking bench for fu_dispatch. Accepted legal inputs are pushed to a
// scoreboard (unit, payload, expected tag); every dispatch strobe pops and
// compares. Scenario tasks add their own inline checks.
// ---------------------------------------------------------------------------
module tb_fu_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_fu_type;
    logic [63:0] in_payload;
    logic        alu_valid, lsq_valid, bra_valid;
    logic [63:0] out_payload;
    logic [3:0]  out_tag;
    logic        alu_free, lsq_free, bra_free;
    logic        illegal;

    always #5 clk = ~clk;

    fu_dispatch dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fu_type(in_fu_type), .in_payload(in_payload),
        .alu_valid(alu_valid), .lsq_valid(lsq_valid), .bra_valid(bra_valid),
        .out_payload(out_payload), .out_tag(out_tag),
        .alu_free(alu_free), .lsq_free(lsq_free), .bra_free(bra_free),
        .illegal(illegal)
    );

    typedef struct packed {
        logic [2:0]  unit;
        logic [63:0] payload;
        logic [3:0]  tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    logic [3:0] tag_model;

    int errors = 0;
    int checks = 0;
    int n_alu, n_lsq, n_bra, n_ill;
    logic obs_in_ready, obs_alu, obs_lsq, obs_bra, obs_ill;
    logic [3:0] obs_tag;

    function automatic logic legal_type(input logic [2:0] t);
        return (t == 3'b001) || (t == 3'b010) || (t == 3'b100);
    endfunction

    // Scoreboard: each strobe must match the oldest accepted legal input.
    always @(negedge clk) begin
        if (!rst && (alu_valid || lsq_valid || bra_valid)) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: strobe bra/lsq/alu=%b tag=%0d, required no strobe",
                         {bra_valid, lsq_valid, alu_valid}, out_tag);
            end else begin
                mon_e = sb.pop_front();
                if ({bra_valid, lsq_valid, alu_valid} !== mon_e.unit ||
                    out_payload !== mon_e.payload || out_tag !== mon_e.tag) begin
                    errors++;
                    $display("FAIL sb_dispatch: got unit=%b payload=%h tag=%0d, required unit=%b payload=%h tag=%0d",
                             {bra_valid, lsq_valid, alu_valid}, out_payload, out_tag,
                             mon_e.unit, mon_e.payload, mon_e.tag);
                end else begin
                    $display("dispatch unit=%b tag=%0d payload=%h", mon_e.unit, mon_e.tag, mon_e.payload);
                end
            end
        end
    end

    // One clock cycle: sample mid-cycle, record accepted inputs, then cross the edge.
    task automatic tick();
        @(negedge clk);
        obs_in_ready = in_ready;
        obs_alu      = alu_valid;
        obs_lsq      = lsq_valid;
        obs_bra      = bra_valid;
        obs_ill      = illegal;
        obs_tag      = out_tag;
        n_alu += int'(alu_valid);
        n_lsq += int'(lsq_valid);
        n_bra += int'(bra_valid);
        n_ill += int'(illegal);
        if (!rst && !flush && in_valid && in_ready && legal_type(in_fu_type)) begin
            sb.push_back(exp_t'{unit: in_fu_type, payload: in_payload, tag: tag_model});
            tag_model++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_alu = 0; n_lsq = 0; n_bra = 0; n_ill = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        tag_model = '0;
    endtask

    task automatic send(input logic [2:0] t);
        in_valid   = 1'b1;
        in_fu_type = t;
        in_payload = {$urandom, $urandom};
        tick();
        in_valid   = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        #2;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
        checks++;
        if ({alu_valid, lsq_valid, bra_valid, illegal} !== 4'b0000) begin
            errors++; $display("FAIL reset_strobes: got %b, required 0000", {alu_valid, lsq_valid, bra_valid, illegal});
        end
        checks++;
        if (out_tag !== 4'd0 || out_payload !== 64'd0) begin
            errors++; $display("FAIL reset_tag_payload: got tag=%0d payload=%h, required 0/0", out_tag, out_payload);
        end
        checks++;
        if (dut.u_alu_credit.credit !== 3'd4 || dut.u_lsq_credit.credit !== 3'd4 || dut.u_bra_credit.credit !== 2'd2) begin
            errors++; $display("FAIL reset_credits: got %0d/%0d/%0d, required 4/4/2",
                               dut.u_alu_credit.credit, dut.u_lsq_credit.credit, dut.u_bra_credit.credit);
        end
        $display("reset checked");
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        tag_model = '0;
    endtask

    // Five back-to-back ALU inputs: four dispatch (tags 0..3), the fifth stalls.
    task automatic test_back_to_back();
        do_reset();
        clear_counts();
        for (int i = 0; i < 5; i++) begin
            in_valid   = 1'b1;
            in_fu_type = 3'b001;
            in_payload = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (obs_in_ready !== 1'b0 || obs_alu !== 1'b0) begin
            errors++; $display("FAIL b2b_stall: got in_ready=%b alu_valid=%b, required 0/0", obs_in_ready, obs_alu);
        end
        checks++;
        if (n_alu != 4) begin errors++; $display("FAIL b2b_count: got %0d strobes, required 4", n_alu); end
    endtask

    // Continues from the ALU stall: a free at cycle T dispatches at T+1.
    task automatic test_credit_return();
        tick();
        checks++;
        if (obs_in_ready !== 1'b0) begin errors++; $display("FAIL credit_still_stalled: got in_ready=%b, required 0", obs_in_ready); end
        alu_free = 1'b1;
        tick();
        alu_free = 1'b0;
        checks++;
        if (obs_alu !== 1'b0) begin errors++; $display("FAIL credit_cycle_T: got alu_valid=%b, required 0", obs_alu); end
        tick();
        checks++;
        if (obs_alu !== 1'b1 || obs_in_ready !== 1'b1) begin
            errors++; $display("FAIL credit_cycle_T1: got alu_valid=%b in_ready=%b, required 1/1", obs_alu, obs_in_ready);
        end
        // Return all four slots plus one extra, which must saturate.
        alu_free = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        alu_free = 1'b0;
        checks++;
        if (dut.u_alu_credit.credit !== 3'd4) begin
            errors++; $display("FAIL credit_saturate: got %0d, required 4", dut.u_alu_credit.credit);
        end
    endtask

    task automatic test_bra_same_cycle();
        clear_counts();
        send(3'b100);
        bra_free = 1'b1;
        tick();
        bra_free = 1'b0;
        checks++;
        if (obs_bra !== 1'b1) begin errors++; $display("FAIL bra_dispatch: got bra_valid=%b, required 1", obs_bra); end
        checks++;
        if (dut.u_bra_credit.credit !== 2'd2) begin
            errors++; $display("FAIL bra_take_give: got credit %0d, required 2", dut.u_bra_credit.credit);
        end
    endtask

    task automatic test_illegal();
        logic [2:0] bad [3];
        bad[0] = 3'b011; bad[1] = 3'b000; bad[2] = 3'b110;
        for (int i = 0; i < 3; i++) begin
            clear_counts();
            send(bad[i]);
            tick();
            checks++;
            if (obs_ill !== 1'b1 || obs_in_ready !== 1'b1) begin
                errors++; $display("FAIL illegal_pulse[%b]: got illegal=%b in_ready=%b, required 1/1", bad[i], obs_ill, obs_in_ready);
            end
            tick();
            checks++;
            if (n_ill != 1 || (n_alu + n_lsq + n_bra) != 0 || out_tag !== tag_model) begin
                errors++; $display("FAIL illegal_effect[%b]: got pulses=%0d strobes=%0d tag=%0d, required 1/0/%0d",
                                   bad[i], n_ill, n_alu + n_lsq + n_bra, out_tag, tag_model);
            end
        end
    endtask

    task automatic test_tag_wrap();
        do_reset();
        clear_counts();
        lsq_free = 1'b1;
        for (int i = 0; i < 17; i++) begin
            in_valid   = 1'b1;
            in_fu_type = 3'b010;
            in_payload = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        tick();
        lsq_free = 1'b0;
        checks++;
        if (n_lsq != 17 || obs_lsq !== 1'b1 || obs_tag !== 4'd0) begin
            errors++; $display("FAIL tag_wrap: got strobes=%0d last_lsq=%b last_tag=%0d, required 17/1/0", n_lsq, obs_lsq, obs_tag);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) send(3'b001);
        tick();
        checks++;
        if (obs_in_ready !== 1'b0 || obs_tag !== 4'd4) begin
            errors++; $display("FAIL flush_setup: got in_ready=%b tag=%0d, required 0/4", obs_in_ready, obs_tag);
        end
        clear_counts();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        sb.delete();
        tag_model = '0;
        tick();
        checks++;
        if (obs_in_ready !== 1'b1 || obs_tag !== 4'd0 || n_alu != 0) begin
            errors++; $display("FAIL flush_effect: got in_ready=%b tag=%0d strobes=%0d, required 1/0/0", obs_in_ready, obs_tag, n_alu);
        end
        checks++;
        if (dut.u_alu_credit.credit !== 3'd0) begin
            errors++; $display("FAIL flush_credit: got %0d, required 0", dut.u_alu_credit.credit);
        end
        // Reset while a held entry is stalled drops it with no strobe.
        send(3'b001);
        tick();
        clear_counts();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (alu_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_stall: got alu_valid=%b in_ready=%b, required 0/1", alu_valid, in_ready);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        tag_model = '0;
        tick();
        tick();
        checks++;
        if (n_alu != 0 || dut.u_alu_credit.credit !== 3'd4) begin
            errors++; $display("FAIL reset_drop: got strobes=%0d credit=%0d, required 0/4", n_alu, dut.u_alu_credit.credit);
        end
    endtask

    initial begin
        flush = 1'b0; in_valid = 1'b0; in_fu_type = 3'b000; in_payload = '0;
        alu_free = 1'b0; lsq_free = 1'b0; bra_free = 1'b0;
        tag_model = '0;
        clear_counts();
        test_reset();
        test_back_to_back();
        test_credit_return();
        test_bra_same_cycle();
        test_illegal();
        test_tag_wrap();
        test_flush();
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fu_dispatch.md
FU_DISPATCH -- requirements
Module: fu_dispatch

Interface
REQ-001 Parameters (name, default, meaning):
- PAYLOAD_W, 64, decoded-instruction payload width.
- TAG_W, 4, dispatch tag width.
- ALU_DEPTH, 4, ALU reservation-station slots.
- LSQ_DEPTH, 4, LSQ slots.
- BRA_DEPTH, 2, branch-unit slots.
REQ-002 Ports (name, direction, width, meaning); one clock; reset is asynchronous and active-high:
- clk, in, 1, clock.
- rst, in, 1, async active-high reset.
- flush, in, 1, pipeline flush.
- in_valid, in, 1, decoder output valid.
- in_ready, out, 1, dispatch can accept.
- in_fu_type, in, 3, one-hot FU select (FU_ALU=001, FU_LSQ=010, FU_BRA=100).
- in_payload, in, PAYLOAD_W, decoded control and operand fields.
- alu_valid / lsq_valid / bra_valid, out, 1 each, dispatch strobe to that unit.
- out_payload, out, PAYLOAD_W, held payload.
- out_tag, out, TAG_W, tag of the dispatched instruction.
- alu_free / lsq_free / bra_free, in, 1 each, one-slot credit return pulse.
- illegal, out, 1, one-cycle pulse when a bad fu_type is discarded.

Function
REQ-003 A one-entry holding register (full flag, fu_type, payload) SHALL capture the input on the edge where in_valid & in_ready.
REQ-004 in_ready SHALL be combinational: !full | fire, where fire is the held entry dispatching or being discarded this cycle, giving back-to-back throughput of 1 instruction per cycle.
REQ-005 Each unit SHALL have a credit counter of width clog2(DEPTH+1), reset to DEPTH.
REQ-006 alu_valid SHALL be asserted as full & fu_type==FU_ALU & alu_credit!=0; lsq_valid and bra_valid SHALL be formed the same way from their own type and credit.
REQ-007 A dispatch strobe SHALL decrement its credit and a free pulse SHALL increment it; when both occur in the same cycle, the credit SHALL be unchanged.
REQ-008 A free pulse while credit==DEPTH SHALL be ignored and the counter SHALL saturate.
REQ-009 When credit==0, the entry SHALL stall and in_ready SHALL be 0 until a free pulse arrives; dispatch SHALL occur in the cycle the credit becomes nonzero (it is registered, so visible the cycle after the free pulse).
REQ-010 out_tag SHALL be driven from a TAG_W counter that increments on every dispatch strobe and wraps from 2^TAG_W-1 to 0.
REQ-011 A held fu_type that is 000 or not one-hot SHALL be discarded in one cycle: no strobe, illegal=1, no credit or tag change.
REQ-012 Flush SHALL clear full and reset the tag counter to 0 at the next edge, SHALL suppress all strobes and input capture in that cycle, and SHALL leave credits untouched (the units return their own credits).
REQ-013 Latency: an input accepted at edge N SHALL dispatch in cycle N+1 when credit is available.

Reset
REQ-014 While rst is asserted (asynchronously):
- full=0 and in_ready=1.
- all strobes=0 and illegal=0.
- credits=DEPTH each.
- tag=0.
- out_payload=0.
REQ-015 A reset mid-stall SHALL drop the held entry with no strobe.

Configuration
REQ-016 With DISPATCH_STATS_EN defined, the block SHALL add 32-bit outputs stall_cycles (cycles with full & no fire) and dispatch_count (number of strobes). Both SHALL saturate at 0xFFFFFFFF and reset to 0. Without the macro, these ports and counters SHALL be absent.

Structure
REQ-017 The FU_ALU, FU_LSQ and FU_BRA encodings and the FU-type width SHALL live in the shared defines package used by the decoder.
REQ-018 A single credit_counter sub-module (parameter DEPTH; inputs take and give; output credit) SHALL be instantiated three times.

Verification
REQ-019 The bench SHALL cover these scenarios:
- Reset, then 4 ALU inputs on consecutive cycles with no free pulses -> 4 alu_valid strobes, tags 0 to 3, and the 5th ALU input stalls with in_ready=0.
- Stalled on ALU at credit 0, alu_free pulse at cycle T -> alu_valid in cycle T+1 and in_ready returns to 1.
- BRA credit 2, dispatch and bra_free in the same cycle -> credit stays 2.
- in_fu_type=011 -> illegal pulses once, no strobe, tag unchanged.
- 17 dispatches -> out_tag sequence 0..15 then 0.
- flush while the entry is held and stalled -> no strobe, tag resets to 0, credits unchanged, and in_ready=1 the next cycle.
